// File: rtl/spi_arb_pkg.sv
// Shared constants and types for the SPI transmitter arbiter.
package spi_arb_pkg;

   localparam int SPI_BYTE_W = 8;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_XFER  = 2'd1,
      S_DRAIN = 2'd2
   } arb_state_e;

   // Index width for n requesters; a single requester still gets one bit.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester after last_grant, wrapping.
module rr_arbiter
   import spi_arb_pkg::*;
#(
   parameter  int NUM_REQ = 2,
   localparam int IW      = idx_w(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [IW-1:0]      last_grant_i,
   output logic [IW-1:0]      grant_idx_o,
   output logic               any_req_o
);

   always_comb begin
      grant_idx_o = last_grant_i;
      any_req_o   = |req_i;
      // Scan offsets from farthest to nearest so the nearest valid one wins.
      for (int i = NUM_REQ; i >= 1; i--) begin
         for (int j = 0; j < NUM_REQ; j++) begin
            if ((j == (int'(last_grant_i) + i) % NUM_REQ) && req_i[j]) begin
               grant_idx_o = IW'(j);
            end
         end
      end
   end

endmodule

// File: rtl/spi_tx_arbiter.sv
// Packet-based round-robin sharing of one SPI byte transmitter, with drain
// wait on the synchronised busy flag so every packet gets its own ss frame.
module spi_tx_arbiter
   import spi_arb_pkg::*;
#(
   parameter int NUM_REQ   = 2,
   parameter int TIMEOUT   = 255,
   parameter int DRAIN_MIN = 4
) (
   input  logic                           clk_i,
   input  logic                           reset_i,
   input  logic [NUM_REQ-1:0]             req_valid_i,
   input  logic [NUM_REQ*SPI_BYTE_W-1:0]  req_data_i,
   input  logic [NUM_REQ-1:0]             req_last_i,
   output logic [NUM_REQ-1:0]             req_ready_o,
   output logic [SPI_BYTE_W-1:0]          spi_value_o,
   output logic                           spi_interrupt_o,
   input  logic                           spi_full_i,
   input  logic                           spi_busy_i,
   output logic [NUM_REQ-1:0]             sel_o,
   output logic                           grant_active_o
);

   localparam int IW = idx_w(NUM_REQ);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam int DW = (DRAIN_MIN > 0) ? $clog2(DRAIN_MIN + 1) : 1;

   arb_state_e         state_q, state_d;
   logic [IW-1:0]      g_q, g_d;
   logic [IW-1:0]      last_q, last_d;
   logic [NUM_REQ-1:0] sel_q, sel_d;
   logic [TW-1:0]      tcnt_q, tcnt_d;
   logic [DW-1:0]      dcnt_q, dcnt_d;
   logic               busy_meta_q, busy_s_q;

   logic [IW-1:0]         pick_idx;
   logic                  any_req;
   logic [NUM_REQ-1:0]    pick_onehot;
   logic                  cur_valid, cur_last, accept;
   logic [SPI_BYTE_W-1:0] cur_data;

   rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
      .req_i        (req_valid_i),
      .last_grant_i (last_q),
      .grant_idx_o  (pick_idx),
      .any_req_o    (any_req)
   );

   always_comb begin
      cur_valid   = 1'b0;
      cur_last    = 1'b0;
      cur_data    = '0;
      pick_onehot = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (g_q == IW'(i)) begin
            cur_valid = req_valid_i[i];
            cur_last  = req_last_i[i];
            cur_data  = req_data_i[i*SPI_BYTE_W +: SPI_BYTE_W];
         end
         if (pick_idx == IW'(i)) pick_onehot[i] = 1'b1;
      end
   end

   // Gated by reset so a reset cycle never leaks a strobe to the transmitter.
   assign accept          = (state_q == S_XFER) & cur_valid & ~spi_full_i & ~reset_i;
   assign spi_interrupt_o = accept;
   assign spi_value_o     = (state_q == S_XFER) ? cur_data : '0;
   assign req_ready_o     = accept ? sel_q : '0;
   assign sel_o           = sel_q;
   assign grant_active_o  = (state_q == S_XFER);

   always_comb begin
      state_d = state_q;
      g_d     = g_q;
      last_d  = last_q;
      sel_d   = sel_q;
      tcnt_d  = tcnt_q;
      dcnt_d  = dcnt_q;
      case (state_q)
         S_IDLE: begin
            tcnt_d = '0;
            dcnt_d = '0;
            if (any_req) begin
               g_d     = pick_idx;
               sel_d   = pick_onehot;
               state_d = S_XFER;
            end
         end
         S_XFER: begin
            if (accept)                      tcnt_d = '0;
            else if (tcnt_q < TW'(TIMEOUT))  tcnt_d = tcnt_q + TW'(1);
            if ((accept && cur_last) || (tcnt_d == TW'(TIMEOUT))) begin
               state_d = S_DRAIN;
               dcnt_d  = '0;
            end
         end
         S_DRAIN: begin
            if (dcnt_q < DW'(DRAIN_MIN)) begin
               dcnt_d = dcnt_q + DW'(1);
            end else if (!busy_s_q) begin
               sel_d   = '0;
               last_d  = g_q;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q     <= S_IDLE;
         g_q         <= '0;
         last_q      <= IW'(NUM_REQ - 1);
         sel_q       <= '0;
         tcnt_q      <= '0;
         dcnt_q      <= '0;
         busy_meta_q <= 1'b0;
         busy_s_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         g_q         <= g_d;
         last_q      <= last_d;
         sel_q       <= sel_d;
         tcnt_q      <= tcnt_d;
         dcnt_q      <= dcnt_d;
         busy_meta_q <= spi_busy_i;
         busy_s_q    <= busy_meta_q;
      end
   end

endmodule

// File: tb/tb_spi_tx_arbiter.sv
// Directed bench for spi_tx_arbiter: NUM_REQ=2, TIMEOUT=8, DRAIN_MIN=4.
module tb_spi_tx_arbiter;

   localparam int N  = 2;
   localparam int TO = 8;
   localparam int DM = 4;

   logic          clk, reset;
   logic [N-1:0]  req_valid, req_last, req_ready, sel;
   logic [N*8-1:0] req_data;
   logic [7:0]    spi_value;
   logic          spi_interrupt, spi_full, spi_busy, grant_active;

   int tests, fails;

   spi_tx_arbiter #(.NUM_REQ(N), .TIMEOUT(TO), .DRAIN_MIN(DM)) dut (
      .clk_i           (clk),
      .reset_i         (reset),
      .req_valid_i     (req_valid),
      .req_data_i      (req_data),
      .req_last_i      (req_last),
      .req_ready_o     (req_ready),
      .spi_value_o     (spi_value),
      .spi_interrupt_o (spi_interrupt),
      .spi_full_i      (spi_full),
      .spi_busy_i      (spi_busy),
      .sel_o           (sel),
      .grant_active_o  (grant_active)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic put(input int r, input logic v, input logic [7:0] d, input logic l);
      req_valid[r]       = v;
      req_data[r*8 +: 8] = d;
      req_last[r]        = l;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
   endtask

   // Polls sel at negedge+1 for up to max further cycles.
   task automatic wait_sel(input logic [1:0] v, input int max, output bit ok);
      ok = 1'b0;
      for (int i = 0; i <= max; i++) begin
         if (sel === v) begin
            ok = 1'b1;
            break;
         end
         if (i < max) begin
            @(negedge clk);
            #1;
         end
      end
   endtask

   task automatic test_reset();
      req_valid = 2'b11;
      repeat (2) @(negedge clk);
      #1;
      tests++; if (sel !== 2'b00) begin fails++; $display("FAIL rst_sel got=%b exp=00", sel); end
      tests++; if (grant_active !== 1'b0) begin fails++; $display("FAIL rst_ga got=%b exp=0", grant_active); end
      tests++; if (req_ready !== 2'b00) begin fails++; $display("FAIL rst_ready got=%b exp=00", req_ready); end
      tests++; if (spi_interrupt !== 1'b0) begin fails++; $display("FAIL rst_int got=%b exp=0", spi_interrupt); end
      tests++; if (spi_value !== 8'h00) begin fails++; $display("FAIL rst_value got=%h exp=00", spi_value); end
      req_valid = 2'b00;
      reset     = 1'b0;
   endtask

   task automatic test_single();
      bit ok;
      @(negedge clk); put(0, 1'b1, 8'hA1, 1'b0); #1;
      tests++; if (sel !== 2'b00 || spi_interrupt !== 1'b0) begin fails++; $display("FAIL t1_idle sel=%b int=%b exp 00/0", sel, spi_interrupt); end
      @(negedge clk); #1;
      tests++; if (sel !== 2'b01 || grant_active !== 1'b1) begin fails++; $display("FAIL t1_grant sel=%b ga=%b exp 01/1", sel, grant_active); end
      tests++; if (spi_interrupt !== 1'b1 || spi_value !== 8'hA1 || req_ready !== 2'b01) begin fails++; $display("FAIL t1_a1 int=%b val=%h rdy=%b exp 1/a1/01", spi_interrupt, spi_value, req_ready); end
      @(negedge clk); put(0, 1'b1, 8'hA2, 1'b0); #1;
      tests++; if (spi_interrupt !== 1'b1 || spi_value !== 8'hA2) begin fails++; $display("FAIL t1_a2 int=%b val=%h exp 1/a2", spi_interrupt, spi_value); end
      @(negedge clk); put(0, 1'b1, 8'hA3, 1'b1); #1;
      tests++; if (spi_interrupt !== 1'b1 || spi_value !== 8'hA3 || req_ready !== 2'b01) begin fails++; $display("FAIL t1_a3 int=%b val=%h rdy=%b exp 1/a3/01", spi_interrupt, spi_value, req_ready); end
      @(negedge clk); put(0, 1'b0, 8'h00, 1'b0); #1;
      tests++; if (grant_active !== 1'b0 || sel !== 2'b01 || spi_interrupt !== 1'b0) begin fails++; $display("FAIL t1_drain ga=%b sel=%b int=%b exp 0/01/0", grant_active, sel, spi_interrupt); end
      for (int k = 0; k < DM - 1; k++) begin
         @(negedge clk); #1;
         tests++; if (sel !== 2'b01) begin fails++; $display("FAIL t1_drain_hold cyc=%0d sel=%b exp 01", k, sel); end
      end
      wait_sel(2'b00, 4, ok);
      tests++; if (!ok) begin fails++; $display("FAIL t1_release sel=%b exp 00 within bound", sel); end
   endtask

   task automatic test_contest();
      bit ok;
      do_reset();
      put(0, 1'b1, 8'hB1, 1'b0); put(1, 1'b1, 8'hC1, 1'b0); #1;
      tests++; if (sel !== 2'b00) begin fails++; $display("FAIL t2_idle sel=%b exp 00", sel); end
      @(negedge clk); #1;
      tests++; if (sel !== 2'b01 || spi_value !== 8'hB1 || req_ready !== 2'b01) begin fails++; $display("FAIL t2_b1 sel=%b val=%h rdy=%b exp 01/b1/01", sel, spi_value, req_ready); end
      @(negedge clk); put(0, 1'b1, 8'hB2, 1'b1); #1;
      tests++; if (spi_value !== 8'hB2 || req_ready !== 2'b01) begin fails++; $display("FAIL t2_b2 val=%h rdy=%b exp b2/01", spi_value, req_ready); end
      @(negedge clk); put(0, 1'b0, 8'h00, 1'b0); #1;
      tests++; if (sel !== 2'b01 || grant_active !== 1'b0 || req_ready !== 2'b00) begin fails++; $display("FAIL t2_drain0 sel=%b ga=%b rdy=%b exp 01/0/00", sel, grant_active, req_ready); end
      wait_sel(2'b00, 10, ok);
      tests++; if (!ok || req_ready !== 2'b00) begin fails++; $display("FAIL t2_gap sel=%b rdy=%b exp 00/00", sel, req_ready); end
      @(negedge clk); #1;
      tests++; if (sel !== 2'b10 || spi_value !== 8'hC1 || req_ready !== 2'b10) begin fails++; $display("FAIL t2_c1 sel=%b val=%h rdy=%b exp 10/c1/10", sel, spi_value, req_ready); end
      @(negedge clk); put(1, 1'b1, 8'hC2, 1'b1); #1;
      tests++; if (spi_value !== 8'hC2 || req_ready !== 2'b10) begin fails++; $display("FAIL t2_c2 val=%h rdy=%b exp c2/10", spi_value, req_ready); end
      @(negedge clk); put(1, 1'b0, 8'h00, 1'b0);
      wait_sel(2'b00, 10, ok);
      tests++; if (!ok) begin fails++; $display("FAIL t2_release1 sel=%b exp 00", sel); end
      put(0, 1'b1, 8'hD1, 1'b1); put(1, 1'b1, 8'hD2, 1'b1);
      @(negedge clk); #1;
      tests++; if (sel !== 2'b01 || spi_value !== 8'hD1) begin fails++; $display("FAIL t2_next sel=%b val=%h exp 01/d1", sel, spi_value); end
      @(negedge clk); put(0, 1'b0, 8'h00, 1'b0); put(1, 1'b0, 8'h00, 1'b0);
      wait_sel(2'b00, 10, ok);
      tests++; if (!ok) begin fails++; $display("FAIL t2_release2 sel=%b exp 00", sel); end
   endtask

   task automatic test_timeout();
      bit ok;
      put(1, 1'b1, 8'hE1, 1'b0);
      @(negedge clk); #1;
      tests++; if (sel !== 2'b10 || spi_value !== 8'hE1 || req_ready !== 2'b10) begin fails++; $display("FAIL t3_e1 sel=%b val=%h rdy=%b exp 10/e1/10", sel, spi_value, req_ready); end
      for (int k = 1; k <= TO; k++) begin
         @(negedge clk);
         if (k == 1) put(1, 1'b0, 8'h00, 1'b0);
         #1;
         tests++; if (grant_active !== 1'b1 || req_ready !== 2'b00) begin fails++; $display("FAIL t3_wait cyc=%0d ga=%b rdy=%b exp 1/00", k, grant_active, req_ready); end
      end
      @(negedge clk); put(1, 1'b1, 8'hE2, 1'b0); #1;
      tests++; if (grant_active !== 1'b0 || sel !== 2'b10 || req_ready !== 2'b00 || spi_interrupt !== 1'b0) begin fails++; $display("FAIL t3_forced ga=%b sel=%b rdy=%b int=%b exp 0/10/00/0", grant_active, sel, req_ready, spi_interrupt); end
      for (int k = 0; k < 3; k++) begin
         @(negedge clk); #1;
         tests++; if (req_ready !== 2'b00) begin fails++; $display("FAIL t3_noready cyc=%0d rdy=%b exp 00", k, req_ready); end
      end
      @(negedge clk); put(1, 1'b0, 8'h00, 1'b0);
      wait_sel(2'b00, 10, ok);
      tests++; if (!ok) begin fails++; $display("FAIL t3_release sel=%b exp 00", sel); end
   endtask

   task automatic test_full();
      bit ok;
      put(0, 1'b1, 8'hF1, 1'b0);
      @(negedge clk); #1;
      tests++; if (sel !== 2'b01 || spi_interrupt !== 1'b1 || spi_value !== 8'hF1) begin fails++; $display("FAIL t4_f1 sel=%b int=%b val=%h exp 01/1/f1", sel, spi_interrupt, spi_value); end
      @(negedge clk); put(0, 1'b1, 8'hF2, 1'b1); spi_full = 1'b1;
      for (int k = 0; k < 3; k++) begin
         if (k > 0) @(negedge clk);
         #1;
         tests++; if (spi_interrupt !== 1'b0 || req_ready !== 2'b00 || grant_active !== 1'b1) begin fails++; $display("FAIL t4_stall cyc=%0d int=%b rdy=%b ga=%b exp 0/00/1", k, spi_interrupt, req_ready, grant_active); end
      end
      @(negedge clk); spi_full = 1'b0; #1;
      tests++; if (spi_interrupt !== 1'b1 || spi_value !== 8'hF2 || req_ready !== 2'b01) begin fails++; $display("FAIL t4_f2 int=%b val=%h rdy=%b exp 1/f2/01", spi_interrupt, spi_value, req_ready); end
      @(negedge clk); put(0, 1'b0, 8'h00, 1'b0); #1;
      tests++; if (spi_interrupt !== 1'b0 || grant_active !== 1'b0) begin fails++; $display("FAIL t4_nodup int=%b ga=%b exp 0/0", spi_interrupt, grant_active); end
      wait_sel(2'b00, 10, ok);
      tests++; if (!ok) begin fails++; $display("FAIL t4_release sel=%b exp 00", sel); end
   endtask

   task automatic test_busy();
      bit ok;
      put(1, 1'b1, 8'h61, 1'b1);
      @(negedge clk); spi_busy = 1'b1; #1;
      tests++; if (sel !== 2'b10 || spi_interrupt !== 1'b1 || spi_value !== 8'h61) begin fails++; $display("FAIL t5_g1 sel=%b int=%b val=%h exp 10/1/61", sel, spi_interrupt, spi_value); end
      @(negedge clk); put(1, 1'b0, 8'h00, 1'b0); put(0, 1'b1, 8'h71, 1'b1); #1;
      tests++; if (sel !== 2'b10 || grant_active !== 1'b0) begin fails++; $display("FAIL t5_drain sel=%b ga=%b exp 10/0", sel, grant_active); end
      for (int k = 1; k < 20; k++) begin
         @(negedge clk); #1;
         tests++; if (sel !== 2'b10 || grant_active !== 1'b0) begin fails++; $display("FAIL t5_hold cyc=%0d sel=%b ga=%b exp 10/0", k, sel, grant_active); end
      end
      @(negedge clk); spi_busy = 1'b0;
      @(negedge clk); #1;
      tests++; if (sel !== 2'b10) begin fails++; $display("FAIL t5_sync sel=%b exp 10", sel); end
      wait_sel(2'b00, 4, ok);
      tests++; if (!ok) begin fails++; $display("FAIL t5_release sel=%b exp 00", sel); end
      @(negedge clk); #1;
      tests++; if (sel !== 2'b01 || spi_value !== 8'h71 || req_ready !== 2'b01) begin fails++; $display("FAIL t5_next sel=%b val=%h rdy=%b exp 01/71/01", sel, spi_value, req_ready); end
      @(negedge clk); put(0, 1'b0, 8'h00, 1'b0);
      wait_sel(2'b00, 10, ok);
      tests++; if (!ok) begin fails++; $display("FAIL t5_release2 sel=%b exp 00", sel); end
   endtask

   task automatic test_reset_mid();
      bit ok;
      put(1, 1'b1, 8'h81, 1'b0);
      @(negedge clk); #1;
      tests++; if (sel !== 2'b10 || grant_active !== 1'b1 || spi_interrupt !== 1'b1) begin fails++; $display("FAIL t6_xfer sel=%b ga=%b int=%b exp 10/1/1", sel, grant_active, spi_interrupt); end
      @(negedge clk); put(1, 1'b1, 8'h82, 1'b0); reset = 1'b1; #1;
      tests++; if (spi_interrupt !== 1'b0 || req_ready !== 2'b00) begin fails++; $display("FAIL t6_nostrobe int=%b rdy=%b exp 0/00", spi_interrupt, req_ready); end
      @(negedge clk); reset = 1'b0; put(0, 1'b1, 8'h91, 1'b1); #1;
      tests++; if (sel !== 2'b00 || grant_active !== 1'b0 || spi_interrupt !== 1'b0) begin fails++; $display("FAIL t6_idle sel=%b ga=%b int=%b exp 00/0/0", sel, grant_active, spi_interrupt); end
      @(negedge clk); #1;
      tests++; if (sel !== 2'b01 || spi_value !== 8'h91) begin fails++; $display("FAIL t6_first sel=%b val=%h exp 01/91", sel, spi_value); end
      @(negedge clk); put(0, 1'b0, 8'h00, 1'b0); put(1, 1'b0, 8'h00, 1'b0);
      wait_sel(2'b00, 10, ok);
      tests++; if (!ok) begin fails++; $display("FAIL t6_release sel=%b exp 00", sel); end
   endtask

   initial begin
      tests     = 0;
      fails     = 0;
      reset     = 1'b1;
      req_valid = '0;
      req_data  = '0;
      req_last  = '0;
      spi_full  = 1'b0;
      spi_busy  = 1'b0;
      test_reset();
      test_single();
      test_contest();
      test_timeout();
      test_full();
      test_busy();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired before summary");
      $fatal(1);
   end

endmodule
